// File: rtl/firing_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : firing_control_if
//  Description : Bundle of the trigger/target inputs and the command/status
//                outputs of the firing controller.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Signals
//    trigger      raw trigger, asynchronous to clk, active-high
//    round_start  single-cycle synchronous pulse, reload to 3 shots
//    hit          synchronous target-detection level, active-high
//    control[2:0] command code to the shot-counter datapath
//    dp_reset_n   active-low reload strobe to the datapath
//    shot_pulse   one cycle per accepted shot
//    hit_pulse    one cycle on the first hit inside a window
//    miss_pulse   one cycle when a window closes without a hit
//    ready        a trigger edge would currently be accepted
//    out_of_ammo  controller is in EMPTY
//  Modports
//    slave   : the firing controller side
//    master  : the environment driving the controller
// ============================================================================
interface firing_control_if;
   logic       trigger;
   logic       round_start;
   logic       hit;
   logic [2:0] control;
   logic       dp_reset_n;
   logic       shot_pulse;
   logic       hit_pulse;
   logic       miss_pulse;
   logic       ready;
   logic       out_of_ammo;

   modport slave (
      input  trigger,
      input  round_start,
      input  hit,
      output control,
      output dp_reset_n,
      output shot_pulse,
      output hit_pulse,
      output miss_pulse,
      output ready,
      output out_of_ammo
   );

   modport master (
      output trigger,
      output round_start,
      output hit,
      input  control,
      input  dp_reset_n,
      input  shot_pulse,
      input  hit_pulse,
      input  miss_pulse,
      input  ready,
      input  out_of_ammo
   );
endinterface
`default_nettype wire

// File: rtl/firing_control.sv
`default_nettype none
// ============================================================================
//  Module      : firing_control
//  Description : Sequencing controller for the shot-counter datapath. Turns
//                trigger rising edges into single-cycle shot states, enforces
//                a cooldown between shots, times a hit window after every
//                shot and reloads the datapath at round start.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   system clock
//    reset_n  in   asynchronous active-low reset
//    bus_io   --   firing_control_if.slave (trigger, round_start, hit in;
//                  control, dp_reset_n, shot/hit/miss pulses, ready,
//                  out_of_ammo out)
//  Parameters
//    COOLDOWN    cycles after a shot before a new edge is accepted (>= 1)
//    HIT_WINDOW  cycles after a shot during which a hit is credited (>= 1)
// ============================================================================
module firing_control #(
   parameter int COOLDOWN   = 25_000_000,
   parameter int HIT_WINDOW = 5_000_000
) (
   input wire              clk,
   input wire              reset_n,
   firing_control_if.slave bus_io
);

   // The state encoding is the datapath command code: odd codes below 111
   // are the decrement commands, everything else holds the count.
   typedef enum logic [2:0] {
      READY3 = 3'b000,
      SHOT1  = 3'b001,
      READY2 = 3'b010,
      SHOT2  = 3'b011,
      READY1 = 3'b100,
      SHOT3  = 3'b101,
      EMPTY  = 3'b110,
      RELOAD = 3'b111
   } state_t;

   localparam int c_cd_w  = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
   localparam int c_win_w = $clog2(HIT_WINDOW + 1);

   localparam logic [c_cd_w-1:0]  c_cd_load  = c_cd_w'(COOLDOWN - 1);
   localparam logic [c_cd_w-1:0]  c_cd_one   = c_cd_w'(1);
   localparam logic [c_win_w-1:0] c_win_load = c_win_w'(HIT_WINDOW);
   localparam logic [c_win_w-1:0] c_win_one  = c_win_w'(1);

   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q, sync3_q;
   logic [c_cd_w-1:0]    cd_q, cd_d;
   logic                 win_open_q, win_open_d;
   logic [c_win_w-1:0]   win_cnt_q, win_cnt_d;
   logic                 hit_pulse_q, hit_pulse_d;
   logic                 miss_pulse_q, miss_pulse_d;

   logic                 w_rise;
   logic                 w_cd_zero;

   assign w_rise    = sync2_q & ~sync3_q;
   assign w_cd_zero = (cd_q == '0);

   // -------------------------------------------------------------------------
   // State and counter registers. The trigger synchronizer runs freely and is
   // untouched by round_start, so an edge straddling a reload is consumed
   // rather than replayed afterwards.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= READY3;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         sync3_q      <= 1'b0;
         cd_q         <= '0;
         win_open_q   <= 1'b0;
         win_cnt_q    <= '0;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= bus_io.trigger;
         sync2_q      <= sync1_q;
         sync3_q      <= sync2_q;
         cd_q         <= cd_d;
         win_open_q   <= win_open_d;
         win_cnt_q    <= win_cnt_d;
         hit_pulse_q  <= hit_pulse_d;
         miss_pulse_q <= miss_pulse_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      cd_d         = cd_q;
      win_open_d   = win_open_q;
      win_cnt_d    = win_cnt_q;
      hit_pulse_d  = 1'b0;
      miss_pulse_d = 1'b0;

      if (bus_io.round_start) begin
         // Reload wins over any coincident edge or hit; the open window is
         // dropped silently.
         state_d    = RELOAD;
         cd_d       = '0;
         win_open_d = 1'b0;
         win_cnt_d  = '0;
      end else begin
         if (!w_cd_zero) begin
            cd_d = cd_q - c_cd_one;
         end

         // A hit on the last window cycle still counts as a hit.
         if (win_open_q) begin
            if (bus_io.hit) begin
               hit_pulse_d = 1'b1;
               win_open_d  = 1'b0;
            end else if (win_cnt_q == '0) begin
               miss_pulse_d = 1'b1;
               win_open_d   = 1'b0;
            end else begin
               win_cnt_d = win_cnt_q - c_win_one;
            end
         end

         case (state_q)
            READY3, READY2, READY1: begin
               if (w_rise && w_cd_zero) begin
                  case (state_q)
                     READY3:  state_d = SHOT1;
                     READY2:  state_d = SHOT2;
                     default: state_d = SHOT3;
                  endcase
                  // A still-open window is closed as a miss in the same
                  // cycle the new shot is reported.
                  if (win_open_q && !bus_io.hit) begin
                     miss_pulse_d = 1'b1;
                  end
                  win_open_d = 1'b1;
                  win_cnt_d  = c_win_load;
               end
            end
            SHOT1: begin
               state_d = READY2;
               cd_d    = c_cd_load;
            end
            SHOT2: begin
               state_d = READY1;
               cd_d    = c_cd_load;
            end
            SHOT3:   state_d = EMPTY;
            EMPTY:   state_d = EMPTY;
            RELOAD:  state_d = READY3;
            default: state_d = READY3;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Outputs: state register or state decode only, never straight from inputs
   // -------------------------------------------------------------------------
   assign bus_io.control     = state_q;
   assign bus_io.dp_reset_n  = (state_q != RELOAD);
   assign bus_io.shot_pulse  = (state_q == SHOT1) || (state_q == SHOT2) ||
                               (state_q == SHOT3);
   assign bus_io.hit_pulse   = hit_pulse_q;
   assign bus_io.miss_pulse  = miss_pulse_q;
   assign bus_io.ready       = ((state_q == READY3) || (state_q == READY2) ||
                                (state_q == READY1)) && w_cd_zero;
   assign bus_io.out_of_ammo = (state_q == EMPTY);

endmodule
`default_nettype wire

// File: tb/tb_firing_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_firing_control
//  Description : Self-checking bench for firing_control (COOLDOWN=4,
//                HIT_WINDOW=3). A cycle table covers the single-shot, hit,
//                empty and reload scenarios; hand sequences cover held
//                triggers, cooldown rejection and asynchronous reset; random
//                traffic is compared against a timestamp-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_firing_control;

   localparam int COOLDOWN   = 4;
   localparam int HIT_WINDOW = 3;
   localparam int N_ROWS     = 34;
   localparam int N_RAND     = 3000;
   localparam logic [8:0] RESET_VEC = {3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   firing_control_if fc_if();

   firing_control #(
      .COOLDOWN   (COOLDOWN),
      .HIT_WINDOW (HIT_WINDOW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus_io  (fc_if.slave)
   );

   // Stand-in for the shot-counter datapath
   logic [1:0] dp_count;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dp_count <= 2'd3;
      end else if (!fc_if.dp_reset_n) begin
         dp_count <= 2'd3;
      end else begin
         case (fc_if.control)
            3'b001:  dp_count <= 2'd2;
            3'b011:  dp_count <= 2'd1;
            3'b101:  dp_count <= 2'd0;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Reference model: shots left, timestamps for cooldown and window end
   // ------------------------------------------------------------------
   int cyc = 0;
   int shots_left;
   bit in_shot, reloading, win_open, m_hitp, m_missp;
   int ready_at, win_last;
   bit trig_hist[$];

   task automatic model_reset();
      shots_left = 3;
      in_shot    = 1'b0;
      reloading  = 1'b0;
      win_open   = 1'b0;
      m_hitp     = 1'b0;
      m_missp    = 1'b0;
      ready_at   = 0;
      win_last   = 0;
      trig_hist  = '{1'b0, 1'b0, 1'b0};
   endtask

   // Called once per clock edge with the inputs sampled at that edge.
   task automatic model_edge(input bit trig, input bit rs, input bit hit);
      int prev;
      bit rise;
      // Edge recognised two samples late: sample k-2 high, sample k-3 low.
      rise = trig_hist[1] && !trig_hist[2];
      trig_hist.push_front(trig);
      void'(trig_hist.pop_back());
      prev    = cyc;
      cyc     = cyc + 1;
      m_hitp  = 1'b0;
      m_missp = 1'b0;
      if (rs) begin
         reloading  = 1'b1;
         in_shot    = 1'b0;
         shots_left = 3;
         ready_at   = 0;
         win_open   = 1'b0;
      end else begin
         if (win_open) begin
            if (hit) begin
               m_hitp   = 1'b1;
               win_open = 1'b0;
            end else if (prev == win_last) begin
               m_missp  = 1'b1;
               win_open = 1'b0;
            end
         end
         if (reloading) begin
            reloading = 1'b0;
         end else if (in_shot) begin
            in_shot = 1'b0;
         end else if (shots_left > 0 && rise && prev >= ready_at) begin
            if (win_open) m_missp = 1'b1;
            in_shot    = 1'b1;
            shots_left = shots_left - 1;
            ready_at   = cyc + COOLDOWN;
            win_open   = 1'b1;
            win_last   = cyc + HIT_WINDOW;
         end
      end
   endtask

   function automatic logic [8:0] model_vec();
      int   c;
      logic rdy, ooa;
      if (reloading)                        c = 7;
      else if (shots_left == 0 && !in_shot) c = 6;
      else                                  c = 2 * (3 - shots_left) - (in_shot ? 1 : 0);
      rdy = !reloading && !in_shot && shots_left > 0 && cyc >= ready_at;
      ooa = !reloading && !in_shot && shots_left == 0;
      return {c[2:0], in_shot, m_hitp, m_missp, rdy, ooa, !reloading};
   endfunction

   function automatic logic [8:0] dut_vec();
      return {fc_if.control, fc_if.shot_pulse, fc_if.hit_pulse, fc_if.miss_pulse,
              fc_if.ready, fc_if.out_of_ammo, fc_if.dp_reset_n};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: model follows the edge, outputs compared at the falling edge.
   task automatic step();
      @(posedge clk);
      if (!reset_n) model_reset();
      else          model_edge(fc_if.trigger, fc_if.round_start, fc_if.hit);
      @(negedge clk);
      check("model", {7'd0, dut_vec()}, {7'd0, model_vec()});
   endtask

   // ------------------------------------------------------------------
   // Cycle table
   // ------------------------------------------------------------------
   typedef struct {
      logic       trig, rs, hit;
      logic [2:0] ctrl;
      logic       shot, hitp, miss, rdy, ooa, dpr;
      logic [1:0] cnt;
   } vec_t;

   vec_t tbl [N_ROWS];

   task automatic row(input int i, input logic t, input logic rs, input logic h,
                      input logic [2:0] c, input logic s, input logic hp, input logic m,
                      input logic r, input logic o, input logic d, input logic [1:0] n);
      tbl[i] = '{t, rs, h, c, s, hp, m, r, o, d, n};
   endtask

   task automatic fill_table();
      row( 0, 1,0,0, 3'd0, 0,0,0, 1,0,1, 2'd3);
      row( 1, 0,0,0, 3'd0, 0,0,0, 1,0,1, 2'd3);
      row( 2, 0,0,0, 3'd1, 1,0,0, 0,0,1, 2'd3);
      row( 3, 0,0,0, 3'd2, 0,0,0, 0,0,1, 2'd2);
      row( 4, 0,0,0, 3'd2, 0,0,0, 0,0,1, 2'd2);
      row( 5, 0,0,0, 3'd2, 0,0,0, 0,0,1, 2'd2);
      row( 6, 0,0,0, 3'd2, 0,0,1, 1,0,1, 2'd2);
      row( 7, 0,0,0, 3'd2, 0,0,0, 1,0,1, 2'd2);
      row( 8, 1,0,0, 3'd2, 0,0,0, 1,0,1, 2'd2);
      row( 9, 0,0,0, 3'd2, 0,0,0, 1,0,1, 2'd2);
      row(10, 0,0,0, 3'd3, 1,0,0, 0,0,1, 2'd2);
      row(11, 0,0,0, 3'd4, 0,0,0, 0,0,1, 2'd1);
      row(12, 0,0,0, 3'd4, 0,0,0, 0,0,1, 2'd1);
      row(13, 0,0,1, 3'd4, 0,1,0, 0,0,1, 2'd1);
      row(14, 0,0,0, 3'd4, 0,0,0, 1,0,1, 2'd1);
      row(15, 0,0,0, 3'd4, 0,0,0, 1,0,1, 2'd1);
      row(16, 1,0,0, 3'd4, 0,0,0, 1,0,1, 2'd1);
      row(17, 0,0,0, 3'd4, 0,0,0, 1,0,1, 2'd1);
      row(18, 0,0,0, 3'd5, 1,0,0, 0,0,1, 2'd1);
      row(19, 0,0,0, 3'd6, 0,0,0, 0,1,1, 2'd0);
      row(20, 0,0,0, 3'd6, 0,0,0, 0,1,1, 2'd0);
      row(21, 0,0,0, 3'd6, 0,0,0, 0,1,1, 2'd0);
      row(22, 0,0,1, 3'd6, 0,1,0, 0,1,1, 2'd0);
      row(23, 0,0,0, 3'd6, 0,0,0, 0,1,1, 2'd0);
      row(24, 1,0,0, 3'd6, 0,0,0, 0,1,1, 2'd0);
      for (int i = 25; i < 28; i++) row(i, 0,0,0, 3'd6, 0,0,0, 0,1,1, 2'd0);
      row(28, 1,0,0, 3'd6, 0,0,0, 0,1,1, 2'd0);
      row(29, 0,0,0, 3'd6, 0,0,0, 0,1,1, 2'd0);
      row(30, 0,1,0, 3'd7, 0,0,0, 0,0,0, 2'd0);
      for (int i = 31; i < N_ROWS; i++) row(i, 0,0,0, 3'd0, 0,0,0, 1,0,1, 2'd3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  nshots, npulses;
      bit  found;

      fc_if.trigger     = 1'b0;
      fc_if.round_start = 1'b0;
      fc_if.hit         = 1'b0;
      model_reset();

      // Reset values
      @(negedge clk);
      check("reset_outputs", {7'd0, dut_vec()}, {7'd0, RESET_VEC});
      check("reset_dp_count", {14'd0, dp_count}, 16'd3);
      step();
      step();
      reset_n = 1'b1;

      // Table-driven scenarios
      fill_table();
      for (int i = 0; i < N_ROWS; i++) begin
         fc_if.trigger     = tbl[i].trig;
         fc_if.round_start = tbl[i].rs;
         fc_if.hit         = tbl[i].hit;
         step();
         check($sformatf("table_row%0d", i), {5'd0, dut_vec(), dp_count},
               {5'd0, tbl[i].ctrl, tbl[i].shot, tbl[i].hitp, tbl[i].miss,
                tbl[i].rdy, tbl[i].ooa, tbl[i].dpr, tbl[i].cnt});
      end
      fc_if.trigger     = 1'b0;
      fc_if.round_start = 1'b0;
      fc_if.hit         = 1'b0;

      // Trigger held high: exactly one shot
      fc_if.trigger = 1'b1;
      nshots = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (fc_if.shot_pulse) nshots++;
      end
      check("held_trigger_shots", 16'(nshots), 16'd1);
      fc_if.trigger = 1'b0;
      repeat (6) step();

      // New shot, then an edge during cooldown is discarded
      fc_if.trigger = 1'b1;
      step();
      fc_if.trigger = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         step();
         if (fc_if.shot_pulse) found = 1'b1;
      end
      check("shot_seen_before_timeout", {15'd0, found}, 16'd1);
      check("cooldown_ready_c0", {15'd0, fc_if.ready}, 16'd0);
      step();
      check("cooldown_ready_c1", {15'd0, fc_if.ready}, 16'd0);
      fc_if.trigger = 1'b1;
      step();
      check("cooldown_ready_c2", {15'd0, fc_if.ready}, 16'd0);
      fc_if.trigger = 1'b0;
      step();
      check("cooldown_ready_c3", {15'd0, fc_if.ready}, 16'd0);
      step();
      check("cooldown_ready_c4", {15'd0, fc_if.ready}, 16'd1);
      nshots = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (fc_if.shot_pulse) nshots++;
      end
      check("cooldown_edge_discarded", 16'(nshots), 16'd0);

      // Asynchronous reset during an open window in READY2
      fc_if.round_start = 1'b1;
      step();
      fc_if.round_start = 1'b0;
      step();
      fc_if.trigger = 1'b1;
      step();
      fc_if.trigger = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         step();
         if (fc_if.shot_pulse) found = 1'b1;
      end
      check("reload_shot_seen", {15'd0, found}, 16'd1);
      step();
      check("pre_reset_ready2", {13'd0, fc_if.control}, 16'd2);
      reset_n = 1'b0;
      #1;
      check("async_reset_outputs", {7'd0, dut_vec()}, {7'd0, RESET_VEC});
      check("async_reset_dp_count", {14'd0, dp_count}, 16'd3);
      step();
      reset_n = 1'b1;
      npulses = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (fc_if.miss_pulse || fc_if.hit_pulse || fc_if.shot_pulse) npulses++;
      end
      check("no_pulse_after_reset", 16'(npulses), 16'd0);

      // Random traffic against the model
      for (int i = 0; i < N_RAND; i++) begin
         if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
         if ($urandom_range(0, 3) == 0) fc_if.trigger = ~fc_if.trigger;
         fc_if.round_start = ($urandom_range(0, 39) == 0);
         fc_if.hit         = ($urandom_range(0, 4) == 0);
         step();
         reset_n = 1'b1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/firing_control.md
# firing_control

Sequencing controller for the shot-counter datapath. It turns the player's raw trigger into single-cycle fire commands and drives the datapath's 3-bit `control` code so the remaining-shot count steps 3→2→1→0. It also enforces a cooldown between shots, times a hit window after each shot, and reloads the datapath at round start. It sits between the trigger/light-sensor inputs and the shot-counter datapath, and feeds the game-scoring logic.

## Interface
Parameters:
- COOLDOWN, 25_000_000: cycles after a shot before another trigger edge is accepted; minimum 1.
- HIT_WINDOW, 5_000_000: cycles after a shot during which `hit` is credited; minimum 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- trigger  in  1  raw trigger, asynchronous to clk, active-high.
- round_start  in  1  single-cycle pulse, synchronous; reloads to 3 shots.
- hit  in  1  synchronous level from target detection, active-high.
- control  out  3  command code to the shot-counter datapath.
- dp_reset_n  out  1  registered active-low reload to the datapath; ANDed with reset_n at top level.
- shot_pulse  out  1  one cycle per accepted shot.
- hit_pulse  out  1  one cycle on the first hit within a window.
- miss_pulse  out  1  one cycle when a window closes without a hit.
- ready  out  1  high when a trigger edge would currently be accepted.
- out_of_ammo  out  1  high in EMPTY.

## Operation
- FSM state encodings equal the `control` value; `control` is the state register, with no decode.
  - READY3=000, SHOT1=001, READY2=010, SHOT2=011, READY1=100, SHOT3=101, EMPTY=110, RELOAD=111.
  - The datapath acts only on 001/011/101 (count becomes 2/1/0); all other codes hold it.
- Trigger path:
  - 2-flop synchronizer, then a third flop for edge detection: rise = sync2 & ~sync3.
  - Only rising edges count; holding the trigger fires once.
- READYn + rise + cooldown==0 → SHOTn.
  - SHOTn lasts exactly one cycle, then → READY(n-1); SHOT3 → EMPTY.
- Rises while cooldown≠0, in SHOTn, in EMPTY, or in RELOAD are discarded, never queued.
- Cooldown counter:
  - Loaded with COOLDOWN-1 on the SHOT→READY transition.
  - Decrements to 0 and saturates; it is 0 in READY3 after reset or reload.
- Hit window counter:
  - Loaded with HIT_WINDOW on entering SHOTn; `window_open` is set.
  - Decrements each cycle while open.
  - `hit`=1 while open → hit_pulse, window closes.
  - Counter reaches 0 without a hit → miss_pulse, window closes.
  - A hit and expiry in the same cycle counts as a hit.
  - The window continues through EMPTY.
- A new shot while the previous window is open: the old window closes with miss_pulse in the same cycle as the new shot_pulse, and the new window starts.
- round_start (any state) → RELOAD for one cycle.
  - dp_reset_n=0 during RELOAD.
  - Cooldown is cleared, the window is cleared with no pulse, and synchronizer flops are kept.
  - RELOAD → READY3.
  - round_start has priority over a simultaneous rise or hit.
- ready = state∈{READY3, READY2, READY1} & cooldown==0.
- out_of_ammo = (state==EMPTY).

## Timing
- Reset values:
  - state READY3, control=000, dp_reset_n=1, shot/hit/miss pulses 0.
  - ready=1, out_of_ammo=0, counters 0, window closed, sync flops 0.
- Trigger latency:
  - trigger high before edge N → control=00x1 code and shot_pulse visible after edge N+2.
  - The datapath count updates at edge N+3.
- shot_pulse is asserted exactly during the SHOTn cycle; all outputs are registered or state-decoded, with no combinational path from inputs.
- Minimum spacing between shot_pulses is COOLDOWN+1 cycles.
- hit sampled at edge M inside the window → hit_pulse during the cycle after M.
- miss_pulse occurs HIT_WINDOW+1 cycles after shot_pulse.
- round_start sampled at edge R → RELOAD after R; READY3 and dp_reset_n=1 after R+1.
- reset_n assertion mid-shot or mid-window forces reset values immediately; no pulse is emitted.

## Test plan
Run with COOLDOWN=4, HIT_WINDOW=3.
- Reset, then one trigger pulse at edge 10 → control=001 and shot_pulse after edge 12, control=010 after edge 13, datapath count 2; miss_pulse 4 cycles after shot_pulse.
- Three triggers spaced 10 cycles → control sequence 001, 010, 011, 100, 101, 110; out_of_ammo=1; fourth trigger → no shot_pulse, control stays 110.
- Trigger held high 50 cycles → exactly one shot_pulse. A second edge 2 cycles after the first shot → discarded, ready=0 for 4 cycles after SHOT.
- hit=1 one cycle, 2 cycles after shot_pulse → single hit_pulse, no miss_pulse. hit coincident with the final window cycle → hit_pulse only.
- From EMPTY, round_start together with a trigger rise → control=111, dp_reset_n=0 for one cycle, then 000, datapath count 3, no shot_pulse.
- reset_n low for 1 cycle during an open window in READY2 → all outputs at reset values, no miss_pulse afterward.
